// File: rtl/uart_arb_pkg.sv
// Purpose: shared definitions for the UART transmit arbiter and related blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding and default guard/timeout constants.
package uart_arb_pkg;

  // Arbiter FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_GUARD     = 2'd3
  } arb_state_t;

  // Guard gap after busy falls; must track the transmitter's RCONST.
  localparam int DEF_GUARD_CYCLES   = 209;
  // Idle clocks an owner may stall mid-packet before losing the grant.
  localparam int DEF_TIMEOUT_CYCLES = 65535;
  // Timeout counter width; saturates at all-ones.
  localparam int TOUT_CNT_W         = 16;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Purpose: round-robin winner select: first request at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none; pure function of req and ptr.
// Ports: req (N request bits), ptr (start index, must be < N),
//        gnt (one-hot winner), vld (at least one request present).
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic             vld
);

  logic [PTR_W:0]   scan_sum;
  logic [PTR_W-1:0] scan_idx;

  always_comb begin
    gnt      = '0;
    vld      = 1'b0;
    scan_sum = '0;
    scan_idx = '0;
    for (int i = 0; i < N; i++) begin
      // One extra bit keeps ptr+i from overflowing before the wrap.
      scan_sum = {1'b0, ptr} + (PTR_W + 1)'(i);
      if (scan_sum >= (PTR_W + 1)'(N)) begin
        scan_sum = scan_sum - (PTR_W + 1)'(N);
      end
      scan_idx = scan_sum[PTR_W-1:0];
      if (!vld && req[scan_idx]) begin
        gnt[scan_idx] = 1'b1;
        vld           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Purpose: packet-level round-robin arbiter sharing one serial_tx among N_REQ byte streams.
// Latency: req sampled at edge k -> grant after k -> tx_send/ack after k+1.
// Backpressure: requester holds req/data until ack; non-owners wait for packet end or owner timeout.
// Ports: clk, reset (async active-low), req/data/last (per requester), ack/grant (per requester),
//        tx_byte/tx_send (to serial_tx sbyte/send), tx_busy (from serial_tx busy).
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int GUARD_CYCLES   = DEF_GUARD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] data,
  input  logic [N_REQ-1:0]   last,
  output logic [N_REQ-1:0]   ack,
  output logic [N_REQ-1:0]   grant,
  output logic [7:0]         tx_byte,
  output logic               tx_send,
  input  logic               tx_busy
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int GW    = (GUARD_CYCLES < 1) ? 1 : $clog2(GUARD_CYCLES + 1);
  localparam logic [31:0] GUARD_LIM = 32'(GUARD_CYCLES);
  localparam logic [31:0] TOUT_LIM  = 32'(TIMEOUT_CYCLES);

  arb_state_t            state;
  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      owner;
  logic                  pend_last;
  logic                  seen_busy;
  logic                  wb_cnt;
  logic [GW-1:0]         guard_cnt;
  logic [TOUT_CNT_W-1:0] tout_cnt;

  logic [N_REQ-1:0]      pick_gnt;
  logic                  pick_vld;
  logic [PTR_W-1:0]      pick_idx;
  logic                  own_req;
  logic                  own_last;
  logic [7:0]            own_data;
  logic [PTR_W-1:0]      ptr_after_owner;
  logic [TOUT_CNT_W-1:0] tout_nxt;
  logic                  tout_hit;
  logic                  guard_done;

  rr_pick #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .vld (pick_vld)
  );

  // One-hot winner to index, and owner's request lane mux.
  always_comb begin
    pick_idx = '0;
    own_req  = 1'b0;
    own_last = 1'b0;
    own_data = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_gnt[i]) begin
        pick_idx = PTR_W'(i);
      end
      if (owner == PTR_W'(i)) begin
        own_req  = req[i];
        own_last = last[i];
        own_data = data[8*i +: 8];
      end
    end
  end

  assign ptr_after_owner = (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
  assign tout_nxt        = (&tout_cnt) ? tout_cnt : tout_cnt + 1'b1;
  // A limit beyond the counter range is never reached, which also disables it.
  assign tout_hit        = (TOUT_LIM != 32'd0) && (32'(tout_nxt) >= TOUT_LIM);
  assign guard_done      = (32'(guard_cnt) + 32'd1) >= GUARD_LIM;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      owner     <= '0;
      pend_last <= 1'b0;
      seen_busy <= 1'b0;
      wb_cnt    <= 1'b0;
      guard_cnt <= '0;
      tout_cnt  <= '0;
      ack       <= '0;
      grant     <= '0;
      tx_byte   <= 8'h00;
      tx_send   <= 1'b0;
    end else begin
      // ack and tx_send are single-cycle pulses.
      ack     <= '0;
      tx_send <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            owner    <= pick_idx;
            grant    <= pick_gnt;
            tout_cnt <= '0;
            state    <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (own_req) begin
            tx_byte   <= own_data;
            tx_send   <= 1'b1;
            ack       <= grant;
            pend_last <= own_last;
            tout_cnt  <= '0;
            seen_busy <= 1'b0;
            wb_cnt    <= 1'b0;
            state     <= ST_WAIT_BUSY;
          end else if (tout_hit) begin
            // Owner stalled mid-packet: revoke and move priority past it.
            grant    <= '0;
            ptr      <= ptr_after_owner;
            tout_cnt <= '0;
            state    <= ST_IDLE;
          end else begin
            tout_cnt <= tout_nxt;
          end
        end

        ST_WAIT_BUSY: begin
          if (!seen_busy) begin
            // Busy never rising by the second cycle is treated as seen so a
            // missing or dead transmitter cannot wedge the arbiter.
            if (tx_busy || wb_cnt) begin
              seen_busy <= 1'b1;
            end else begin
              wb_cnt <= 1'b1;
            end
          end else if (!tx_busy) begin
            guard_cnt <= '0;
            state     <= ST_GUARD;
          end
        end

        ST_GUARD: begin
          if (guard_done) begin
            guard_cnt <= '0;
            if (pend_last) begin
              grant <= '0;
              ptr   <= ptr_after_owner;
              state <= ST_IDLE;
            end else begin
              state <= ST_SEND;
            end
          end else begin
            guard_cnt <= guard_cnt + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose: directed self-checking bench for uart_tx_arbiter (4 requesters, guard 8, timeout 50).
// Latency: n/a.
// Backpressure: n/a; a tx_busy stub stands in for serial_tx where needed.
module tb_uart_tx_arbiter;

  localparam int N        = 4;
  localparam int G        = 8;
  localparam int TO       = 50;
  localparam int BUSY_LEN = 100;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   req   = '0;
  logic [31:0]  data  = '0;
  logic [3:0]   last  = '0;
  logic         tx_busy = 1'b0;
  logic [3:0]   ack;
  logic [3:0]   grant;
  logic [7:0]   tx_byte;
  logic         tx_send;

  int checks   = 0;
  int failures = 0;
  bit stub_en  = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ          (N),
    .GUARD_CYCLES   (G),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .data    (data),
    .last    (last),
    .ack     (ack),
    .grant   (grant),
    .tx_byte (tx_byte),
    .tx_send (tx_send),
    .tx_busy (tx_busy)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until tx_send is seen (bounded); cyc = edges waited.
  task automatic wait_send(input string tag, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!tx_send && cyc < 400);
    chk_eq({tag, "_sent"}, {31'd0, tx_send}, 32'd1);
  endtask

  // serial_tx stand-in: busy rises the edge after send, stays high BUSY_LEN clocks.
  initial begin
    forever begin
      @(negedge clk);
      if (stub_en && tx_send) begin
        @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (BUSY_LEN) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;

    // Reset state
    repeat (2) tick();
    chk_eq("rst_ack", ack, 0);
    chk_eq("rst_grant", grant, 0);
    chk_eq("rst_tx_byte", tx_byte, 0);
    chk_eq("rst_tx_send", tx_send, 0);
    reset = 1'b1;
    tick();
    chk_eq("idle_grant", grant, 0);

    // Single byte, with busy stub: send at s, release at s+110
    stub_en = 1'b1;
    req = 4'b0001; data[7:0] = 8'h41; last = 4'b0001;
    tick();
    chk_eq("sb_grant", grant, 4'b0001);
    chk_eq("sb_nosend_yet", tx_send, 0);
    tick();
    chk_eq("sb_send", tx_send, 1);
    chk_eq("sb_byte", tx_byte, 8'h41);
    chk_eq("sb_ack", ack, 4'b0001);
    req = 4'b0000; last = 4'b0000;
    tick();
    chk_eq("sb_ack_pulse", ack, 0);
    chk_eq("sb_send_pulse", tx_send, 0);
    repeat (108) tick();
    chk_eq("sb_grant_held", grant, 4'b0001);
    tick();
    chk_eq("sb_grant_rel", grant, 0);
    chk_eq("sb_byte_hold", tx_byte, 8'h41);
    stub_en = 1'b0;

    // Packet lock: requester 1 sends 3 bytes while requester 2 waits
    req = 4'b0110; data[15:8] = 8'h10; data[23:16] = 8'h20; last = 4'b0100;
    for (int b = 0; b < 3; b++) begin
      wait_send("pk", cyc);
      chk_eq("pk_byte", tx_byte, 8'h10 + b);
      chk_eq("pk_ack", ack, 4'b0010);
      chk_eq("pk_grant", grant, 4'b0010);
      if (b < 2) begin
        data[15:8] = 8'h11 + 8'(b);
        last[1] = (b == 1);
      end
    end
    req[1] = 1'b0; last[1] = 1'b0;
    repeat (11) tick();
    chk_eq("pk_gap", grant, 0);
    tick();
    chk_eq("pk_next_owner", grant, 4'b0100);

    // Requester 2's byte, then owner 3 sends one non-last byte and stalls
    req[3] = 1'b1; data[31:24] = 8'h30; last[3] = 1'b0;
    wait_send("r2", cyc);
    chk_eq("r2_byte", tx_byte, 8'h20);
    chk_eq("r2_ack", ack, 4'b0100);
    req[2] = 1'b0; last[2] = 1'b0;
    wait_send("to", cyc);
    chk_eq("to_byte", tx_byte, 8'h30);
    chk_eq("to_ack", ack, 4'b1000);
    req[3] = 1'b0; req[0] = 1'b1; data[7:0] = 8'h50; last[0] = 1'b1;
    // SEND re-entered at s+11, revoked 50 clocks later at s+61
    repeat (60) tick();
    chk_eq("to_grant_held", grant, 4'b1000);
    tick();
    chk_eq("to_grant_rel", grant, 0);
    tick();
    chk_eq("to_ptr_wrap_pick0", grant, 4'b0001);
    wait_send("to0", cyc);
    chk_eq("to0_byte", tx_byte, 8'h50);
    chk_eq("to0_lat", cyc, 1);
    req[0] = 1'b0; last[0] = 1'b0;

    // Guard and busy spacing with stub: 100 + G + 3 clocks between sends
    stub_en = 1'b1;
    req[1] = 1'b1; data[15:8] = 8'h61; last[1] = 1'b0;
    wait_send("sp0", cyc);
    chk_eq("sp0_ack", ack, 4'b0010);
    data[15:8] = 8'h62;
    wait_send("sp1", cyc);
    chk_eq("sp_spacing", cyc, BUSY_LEN + G + 3);
    chk_eq("sp1_byte", tx_byte, 8'h62);

    // Reset mid-frame during WAIT_BUSY
    repeat (5) tick();
    #2 reset = 1'b0;
    #1;
    chk_eq("mr_ack", ack, 0);
    chk_eq("mr_grant", grant, 0);
    chk_eq("mr_tx_byte", tx_byte, 0);
    chk_eq("mr_tx_send", tx_send, 0);
    stub_en = 1'b0;
    req = 4'b1111; data = 32'hA3A2A1A0; last = 4'b1111;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    chk_eq("mr_pick0", grant, 4'b0001);

    // Rotation: order 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      wait_send("rot", cyc);
      chk_eq("rot_ack", ack, 32'd1 << (i % 4));
      chk_eq("rot_byte", tx_byte, 8'hA0 + (i % 4));
    end
    req = 4'b0000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
